// File: rtl/dispatch_ctrl_pkg.sv
// Shared sizing, bus types and FSM encoding for the dispatch controller
// and its ROB tag allocator.
package dispatch_ctrl_pkg;

  localparam int ROB_DEPTH  = 16;
  localparam int NICK_W     = 5;
  localparam int RS_DEPTH   = 16;
  localparam int LSB_DEPTH  = 16;
  localparam int REG_W      = 5;
  localparam int RS_CRED_W  = $clog2(RS_DEPTH + 1);
  localparam int LSB_CRED_W = $clog2(LSB_DEPTH + 1);

  typedef logic [REG_W-1:0]      name_bus_t;
  typedef logic [NICK_W-1:0]     nick_bus_t;
  typedef logic [RS_CRED_W-1:0]  rs_cred_t;
  typedef logic [LSB_CRED_W-1:0] lsb_cred_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Rename write presented to the regfile one cycle after an accept.
  typedef struct packed {
    logic      nick_en;
    name_bus_t regnm;
    nick_bus_t nick;
  } rename_t;

  // Tags live in 1..ROB_DEPTH; 0 is reserved for "no pending producer".
  function automatic nick_bus_t next_tag(input nick_bus_t tag);
    return (tag == nick_bus_t'(ROB_DEPTH)) ? nick_bus_t'(1) : tag + nick_bus_t'(1);
  endfunction

endpackage

// File: rtl/dispatch_ctrl_if.sv
// Decoder-side handshake plus regfile/ROB/RS/LSB signals of the dispatch
// controller, bundled so the top has a single bus port.
interface dispatch_ctrl_if;
  import dispatch_ctrl_pkg::*;

  logic      iDEC_valid;
  logic      oDEC_ready;
  name_bus_t iDEC_rd_regnm;
  logic      iDEC_is_ls;
  logic      iDEC_no_rd;

  logic      oRF_en;
  logic      oRF_nick_en;
  name_bus_t oRF_nick_regnm;
  nick_bus_t oRF_nick;

  logic      oROB_alloc;
  nick_bus_t oROB_tag;
  logic      iROB_commit;
  nick_bus_t oROB_cnt;

  logic      iRS_free;
  logic      iLSB_free;

  // Environment side: decoder and back-end units.
  modport master (
    output iDEC_valid, iDEC_rd_regnm, iDEC_is_ls, iDEC_no_rd,
    output iROB_commit, iRS_free, iLSB_free,
    input  oDEC_ready, oRF_en, oRF_nick_en, oRF_nick_regnm, oRF_nick,
    input  oROB_alloc, oROB_tag, oROB_cnt
  );

  // Dispatch controller side.
  modport slave (
    input  iDEC_valid, iDEC_rd_regnm, iDEC_is_ls, iDEC_no_rd,
    input  iROB_commit, iRS_free, iLSB_free,
    output oDEC_ready, oRF_en, oRF_nick_en, oRF_nick_regnm, oRF_nick,
    output oROB_alloc, oROB_tag, oROB_cnt
  );

endinterface

// File: rtl/dispatch_ctrl_tag_alloc.sv
// ROB tag allocator: wrapping tail pointer that never issues tag 0, plus
// the count of occupied ROB entries.
module dispatch_ctrl_tag_alloc
  import dispatch_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clear,
  input  logic      alloc,
  input  logic      commit,
  output nick_bus_t tail,
  output nick_bus_t cnt,
  output logic      full
);

  logic do_commit;

  // A retire with nothing outstanding is a stale pulse and is dropped.
  assign do_commit = commit & (cnt != '0);
  assign full      = (cnt == nick_bus_t'(ROB_DEPTH));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tail <= nick_bus_t'(1);
      cnt  <= '0;
    end else if (clear) begin
      tail <= nick_bus_t'(1);
      cnt  <= '0;
    end else begin
      if (alloc) tail <= next_tag(tail);
      unique case ({alloc, do_commit})
        2'b10:   cnt <= cnt + nick_bus_t'(1);
        2'b01:   cnt <= cnt - nick_bus_t'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/dispatch_ctrl.sv
// Instruction dispatch sequencer: accepts one decoded instruction per cycle,
// allocates a ROB tag, drives regfile enable/rename write, tracks capacity.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rdy,
  input  logic           clr,
  dispatch_ctrl_if.slave bus
);

  state_e    state_q, state_d;
  logic      dec_ready;
  logic      accept;
  logic      clear;
  logic      credit_ok;
  logic      rob_full;
  nick_bus_t tail;
  nick_bus_t rob_cnt;

  rs_cred_t  rs_credit;
  lsb_cred_t lsb_credit;
  logic      rs_take, rs_give;
  logic      lsb_take, lsb_give;

  logic      rf_en_q;
  nick_bus_t tag_q;
  rename_t   ren_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  assign credit_ok = bus.iDEC_is_ls ? (lsb_credit != '0) : (rs_credit != '0);

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    dec_ready = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (clr) state_d = ST_FLUSH;
        dec_ready = rdy & ~clr & ~rob_full & credit_ok;
      end
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  assign bus.oDEC_ready = dec_ready;
  assign accept         = bus.iDEC_valid & dec_ready;

  // Flush edge and the FLUSH cycle both hold allocation state at reset
  // values; clr takes effect even while rdy is low.
  assign clear = (clr & (state_q == ST_RUN)) | (state_q == ST_FLUSH);

  // ---------------------------------------------------------------- ROB tags
  dispatch_ctrl_tag_alloc u_tag_alloc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .alloc  (accept),
    .commit (bus.iROB_commit & rdy),
    .tail   (tail),
    .cnt    (rob_cnt),
    .full   (rob_full)
  );

  assign bus.oROB_cnt = rob_cnt;

  // ---------------------------------------------------------------- credits
  assign rs_take  = accept & ~bus.iDEC_is_ls;
  assign lsb_take = accept &  bus.iDEC_is_ls;
  assign rs_give  = rdy & bus.iRS_free;
  assign lsb_give = rdy & bus.iLSB_free;

  // Simultaneous take and give cancel; a give at full credit saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_credit  <= rs_cred_t'(RS_DEPTH);
      lsb_credit <= lsb_cred_t'(LSB_DEPTH);
    end else if (clear) begin
      rs_credit  <= rs_cred_t'(RS_DEPTH);
      lsb_credit <= lsb_cred_t'(LSB_DEPTH);
    end else begin
      unique case ({rs_take, rs_give})
        2'b10:   rs_credit <= rs_credit - rs_cred_t'(1);
        2'b01:   if (rs_credit != rs_cred_t'(RS_DEPTH)) rs_credit <= rs_credit + rs_cred_t'(1);
        default: rs_credit <= rs_credit;
      endcase
      unique case ({lsb_take, lsb_give})
        2'b10:   lsb_credit <= lsb_credit - lsb_cred_t'(1);
        2'b01:   if (lsb_credit != lsb_cred_t'(LSB_DEPTH)) lsb_credit <= lsb_credit + lsb_cred_t'(1);
        default: lsb_credit <= lsb_credit;
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs
  // accept already excludes clr, FLUSH and rdy low, so those force zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_en_q <= 1'b0;
      tag_q   <= '0;
      ren_q   <= '0;
    end else begin
      rf_en_q <= accept;
      tag_q   <= accept ? tail : '0;
      if (accept && !bus.iDEC_no_rd && bus.iDEC_rd_regnm != '0)
        ren_q <= '{nick_en: 1'b1, regnm: bus.iDEC_rd_regnm, nick: tail};
      else
        ren_q <= '0;
    end
  end

  assign bus.oRF_en         = rf_en_q;
  assign bus.oROB_alloc     = rf_en_q;
  assign bus.oROB_tag       = tag_q;
  assign bus.oRF_nick_en    = ren_q.nick_en;
  assign bus.oRF_nick_regnm = ren_q.regnm;
  assign bus.oRF_nick       = ren_q.nick;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: stimulus pushes expected dispatches into
// a queue, a negedge monitor pops and compares whatever the DUT presents.
module tb_dispatch_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic rdy;
  logic clr;

  dispatch_ctrl_if bus ();

  dispatch_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .clr   (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nick_en;
    int regnm;
    int nick;
    int tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_tail  = 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at posedge+1, check ready, record expected dispatch,
  // then advance to the next posedge+1 and drop the pulse inputs.
  task automatic step(input int v, input int rd, input int ls, input int nord,
                      input int cm, input int rsf, input int lsf, input int cl,
                      input int exp_rdy, input string name);
    exp_t e;
    bus.iDEC_valid    = v[0];
    bus.iDEC_rd_regnm = 5'(rd);
    bus.iDEC_is_ls    = ls[0];
    bus.iDEC_no_rd    = nord[0];
    bus.iROB_commit   = cm[0];
    bus.iRS_free      = rsf[0];
    bus.iLSB_free     = lsf[0];
    clr               = cl[0];
    #1;
    check({name, " ready"}, int'(bus.oDEC_ready), exp_rdy);
    if (v != 0 && exp_rdy != 0) begin
      e.tag     = m_tail;
      e.nick_en = (nord == 0 && rd != 0) ? 1 : 0;
      e.regnm   = (e.nick_en != 0) ? rd : 0;
      e.nick    = (e.nick_en != 0) ? m_tail : 0;
      exp_q.push_back(e);
      m_tail = (m_tail == 16) ? 1 : m_tail + 1;
    end
    @(posedge clk);
    #1;
    bus.iDEC_valid  = 1'b0;
    bus.iROB_commit = 1'b0;
    bus.iRS_free    = 1'b0;
    bus.iLSB_free   = 1'b0;
    clr             = 1'b0;
  endtask

  // Monitor: any non-zero dispatch output must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (bus.oRF_en || bus.oROB_alloc || bus.oRF_nick_en ||
                  bus.oROB_tag != '0 || bus.oRF_nick != '0 || bus.oRF_nick_regnm != '0)) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected dispatch: tag=%0d nick_en=%0d, expected none (t=%0t)",
                 bus.oROB_tag, bus.oRF_nick_en, $time);
      end else begin
        e = exp_q.pop_front();
        check("mon rf_en",   int'(bus.oRF_en),         1);
        check("mon alloc",   int'(bus.oROB_alloc),     1);
        check("mon tag",     int'(bus.oROB_tag),       e.tag);
        check("mon nick_en", int'(bus.oRF_nick_en),    e.nick_en);
        check("mon regnm",   int'(bus.oRF_nick_regnm), e.regnm);
        check("mon nick",    int'(bus.oRF_nick),       e.nick);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0;
    rdy   = 1'b1;
    clr   = 1'b0;
    bus.iDEC_valid    = 1'b0;
    bus.iDEC_rd_regnm = '0;
    bus.iDEC_is_ls    = 1'b0;
    bus.iDEC_no_rd    = 1'b0;
    bus.iROB_commit   = 1'b0;
    bus.iRS_free      = 1'b0;
    bus.iLSB_free     = 1'b0;

    // Reset state
    #2;
    check("reset rf_en",   int'(bus.oRF_en),      0);
    check("reset alloc",   int'(bus.oROB_alloc),  0);
    check("reset tag",     int'(bus.oROB_tag),    0);
    check("reset nick_en", int'(bus.oRF_nick_en), 0);
    check("reset cnt",     int'(bus.oROB_cnt),    0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready after reset", int'(bus.oDEC_ready), 1);

    // First dispatch: rd=5 to RS -> tag 1, nick 1
    step(1, 5, 0, 0, 0, 0, 0, 0, 1, "first accept");
    check("cnt after first", int'(bus.oROB_cnt), 1);

    // Fill the ROB: tags 2..16
    for (int i = 1; i < 16; i++) step(1, i, i % 2, 0, 0, 0, 0, 0, 1, "fill");
    check("cnt full", int'(bus.oROB_cnt), 16);
    step(1, 7, 0, 0, 1, 0, 0, 0, 0, "full with commit");
    check("cnt after commit", int'(bus.oROB_cnt), 15);
    step(1, 7, 0, 0, 0, 0, 0, 0, 1, "wrap accept");

    // Drain everything, returning all credits (extra frees saturate)
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 1, 1, 1, 0, (i == 0) ? 0 : 1, "drain");
    check("cnt drained", int'(bus.oROB_cnt), 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 1, "commit at empty");
    check("cnt empty commit", int'(bus.oROB_cnt), 0);

    // rd=0 and a store: allocate but no rename
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, "rd zero");
    step(1, 3, 1, 1, 0, 0, 0, 0, 1, "store");
    check("cnt two", int'(bus.oROB_cnt), 2);

    // Exhaust LSB credit (15 left) while commits keep the ROB at 2
    for (int i = 0; i < 15; i++) step(1, i + 1, 1, 0, 1, 0, 0, 0, 1, "ls fill");
    check("cnt steady", int'(bus.oROB_cnt), 2);
    step(1, 9,  1, 0, 0, 0, 1, 0, 0, "lsb empty");
    step(1, 10, 1, 0, 0, 0, 1, 0, 1, "lsb accept+free");
    step(1, 11, 1, 0, 0, 0, 0, 0, 1, "lsb last credit");
    step(1, 12, 1, 0, 0, 0, 0, 0, 0, "lsb empty again");
    step(1, 13, 0, 0, 0, 0, 0, 0, 1, "rs while lsb empty");
    step(1, 14, 0, 0, 0, 0, 0, 0, 1, "rs a");
    step(1, 15, 0, 0, 0, 0, 0, 0, 1, "rs b");
    check("cnt seven", int'(bus.oROB_cnt), 7);

    // Flush during an accept attempt (rob_cnt=7, tail=8)
    step(1, 14, 1, 0, 0, 0, 0, 1, 0, "clr blocks accept");
    check("cnt after clr", int'(bus.oROB_cnt), 0);
    step(1, 15, 0, 0, 1, 1, 1, 1, 0, "flush cycle");
    check("cnt in flush", int'(bus.oROB_cnt), 0);
    m_tail = 1;
    for (int i = 0; i < 16; i++) step(1, i + 1, 1, 0, 0, 0, 0, 0, 1, "post-flush ls");
    check("cnt refilled", int'(bus.oROB_cnt), 16);

    // rdy low: valid and pulses ignored
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1, 4, 0, 0, 1, 1, 1, 0, 0, "rdy low");
      check("cnt rdy low", int'(bus.oROB_cnt), 16);
    end
    rdy = 1'b1;
    step(1, 4, 0, 0, 0, 0, 0, 0, 0, "still full");
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, "commit at full");
    check("cnt after rdy", int'(bus.oROB_cnt), 15);
    step(1, 6, 0, 0, 0, 0, 0, 0, 1, "accept after rdy");

    // Async reset while a dispatch is on the outputs
    e = exp_q.pop_front();
    check("pre-reset rf_en", int'(bus.oRF_en),   1);
    check("pre-reset tag",   int'(bus.oROB_tag), e.tag);
    #1 rst_n = 1'b0;
    #1;
    check("async rf_en",   int'(bus.oRF_en),      0);
    check("async tag",     int'(bus.oROB_tag),    0);
    check("async nick_en", int'(bus.oRF_nick_en), 0);
    check("async cnt",     int'(bus.oROB_cnt),    0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_tail = 1;
    step(1, 8, 0, 0, 0, 0, 0, 0, 1, "after reset");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, "idle");
    check("scoreboard empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
